// File: rtl/dl_service_mux.sv
// Downlink service-channel multiplexer: four per-channel I/Q FIFOs time-division
// multiplexed into one framed valid/ready stream, zero-padding empty slots.
module dl_service_mux #(
  parameter int FIFO_DEPTH = 8,
  parameter int SLOT_LEN   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  s_valid,
  input  logic [15:0] s_i_1,
  input  logic [15:0] s_q_1,
  input  logic [15:0] s_i_2,
  input  logic [15:0] s_q_2,
  input  logic [15:0] s_i_3,
  input  logic [15:0] s_q_3,
  input  logic [15:0] s_i_4,
  input  logic [15:0] s_q_4,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_i,
  output logic [15:0] m_q,
  output logic [1:0]  m_ch,
  output logic        m_sof,
  output logic        m_pad,
  output logic [3:0]  ovf,
  input  logic        ovf_clr
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(SLOT_LEN - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [31:0]   mem_r    [4][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r [4];
  logic [AW-1:0] rd_ptr_r [4];
  logic [CW-1:0] cnt_r    [4];
  logic [31:0]   s_data_s [4];
  logic [3:0]    push_s;
  logic [3:0]    pop_s;
  logic [3:0]    drop_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [1:0]    ch_r;
  logic [1:0]    ch_nxt_s;
  logic [BW-1:0] beat_r;
  logic [BW-1:0] beat_nxt_s;
  logic          load_s;
  logic          head_empty_s;
  logic [31:0]   rd_data_s;

  assign s_data_s[0]  = {s_i_1, s_q_1};
  assign s_data_s[1]  = {s_i_2, s_q_2};
  assign s_data_s[2]  = {s_i_3, s_q_3};
  assign s_data_s[3]  = {s_i_4, s_q_4};
  assign load_s       = (state_r == RUN) && (!m_valid || m_ready);
  assign head_empty_s = (cnt_r[ch_r] == {CW{1'b0}});
  assign rd_data_s    = mem_r[ch_r][rd_ptr_r[ch_r]];

  // Push/pop/drop decisions use pre-edge counts, so a full FIFO drops even when popped.
  always_comb begin
    push_s = 4'b0000;
    pop_s  = 4'b0000;
    drop_s = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (s_valid[k]) begin
        if (cnt_r[k] == FULL_CNT) begin
          drop_s[k] = 1'b1;
        end else begin
          push_s[k] = 1'b1;
        end
      end else begin
        push_s[k] = 1'b0;
      end
      if (load_s && (ch_r == 2'(k)) && (cnt_r[k] != {CW{1'b0}})) begin
        pop_s[k] = 1'b1;
      end else begin
        pop_s[k] = 1'b0;
      end
    end
  end

  // Sample storage; contents are only meaningful through the pointers and counts.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push_s[k]) begin
        mem_r[k][wr_ptr_r[k]] <= s_data_s[k];
      end
    end
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr_r[k] <= {AW{1'b0}};
        rd_ptr_r[k] <= {AW{1'b0}};
        cnt_r[k]    <= {CW{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push_s[k]) begin
          wr_ptr_r[k] <= wr_ptr_r[k] + AW'(1);
        end
        if (pop_s[k]) begin
          rd_ptr_r[k] <= rd_ptr_r[k] + AW'(1);
        end
        cnt_r[k] <= cnt_r[k] + CW'(push_s[k]) - CW'(pop_s[k]);
      end
    end
  end

  // Frame scheduler next state; a started frame always runs to its last beat.
  always_comb begin
    state_nxt_s = state_r;
    ch_nxt_s    = ch_r;
    beat_nxt_s  = beat_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_nxt_s = RUN;
          ch_nxt_s    = 2'd0;
          beat_nxt_s  = {BW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (load_s) begin
          if (beat_r == LAST_BEAT) begin
            beat_nxt_s = {BW{1'b0}};
            if (ch_r == 2'd3) begin
              ch_nxt_s    = 2'd0;
              state_nxt_s = en ? RUN : IDLE;
            end else begin
              ch_nxt_s = ch_r + 2'd1;
            end
          end else begin
            beat_nxt_s = beat_r + BW'(1);
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        ch_nxt_s    = 2'd0;
        beat_nxt_s  = {BW{1'b0}};
      end
    endcase
  end

  // Scheduler state and slot/beat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ch_r    <= 2'd0;
      beat_r  <= {BW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ch_r    <= ch_nxt_s;
      beat_r  <= beat_nxt_s;
    end
  end

  // Output beat register: loads on a free slot, holds under backpressure, drains when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_i     <= 16'h0000;
      m_q     <= 16'h0000;
      m_ch    <= 2'd0;
      m_sof   <= 1'b0;
      m_pad   <= 1'b0;
    end else if (load_s) begin
      m_valid <= 1'b1;
      m_ch    <= ch_r;
      m_sof   <= (ch_r == 2'd0) && (beat_r == {BW{1'b0}});
      m_pad   <= head_empty_s;
      m_i     <= head_empty_s ? 16'h0000 : rd_data_s[31:16];
      m_q     <= head_empty_s ? 16'h0000 : rd_data_s[15:0];
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the clearing cycle keeps its bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 4'b0000;
    end else begin
      ovf <= (ovf_clr ? 4'b0000 : ovf) | drop_s;
    end
  end

endmodule
